// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared types and constants for the unified memory arbiter
//
// Contents:
//   owner_t        who a grant or an outstanding read belongs to
//   MW_B/MW_H/MW_W funct3 access widths (byte, half, word)
//   lat_cnt_width  bits needed to hold a down-counter loaded with a given value
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [2:0] MW_B = 3'b000;
  localparam logic [2:0] MW_H = 3'b001;
  localparam logic [2:0] MW_W = 3'b010;

  function automatic int lat_cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port bundle of the unified memory arbiter
//
// Signals:
//   if_*   instruction-fetch requester: req/addr in, gnt/rvalid/rdata out
//   d_*    MEM-stage data requester: req/we/width/addr/wdata in, gnt/rvalid/rdata out
//   mem_*  single-port memory: en/we/width/addr/wdata out, rdata in
// Modports:
//   slave   the arbiter side
//   master  the requester and memory side
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_width;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_width, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_width, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_width, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_width, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - fetch starvation counter and fetch-priority flag
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   if_req     fetch request
//   if_gnt     fetch granted this cycle
//   if_first   fetch has been denied STARVE_MAX cycles and wins the next arbitration
module mem_arb_starve
  import rv32_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic if_first
);

  localparam int SW = lat_cnt_width(STARVE_MAX);
  localparam logic [SW-1:0] SAT = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  // Every cycle a pending fetch is refused counts, including cycles where
  // nothing could issue because a read was still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (if_req && (starve_cnt != SAT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign if_first = (starve_cnt == SAT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port unified memory arbiter for fetch and data requesters
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   bus           mem_arbiter_if.slave: fetch requester, data requester, memory port
//   conflict_cnt  [31:0] cycles with both requests present and a grant made
//                 (only when MEM_ARB_PERF_EN is defined)
// Parameters:
//   MEM_LAT       read latency from issue to valid mem_rdata (1..7)
//   STARVE_MAX    denied fetch cycles after which fetch wins arbitration
// Build option:
//   MEM_ARB_PERF_EN  adds the conflict_cnt output and counter
module mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]  conflict_cnt
`endif
);

  localparam int LW = lat_cnt_width(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    RD_I,
    RD_D
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          ret;
  logic          if_first;
  owner_t        win;

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .if_gnt   (bus.if_gnt),
    .if_first (if_first)
  );

  // Arbitration: the port is free when idle or in the cycle the outstanding
  // read returns, which allows back-to-back reads every MEM_LAT cycles.
  always_comb begin
    ret = (state_q != IDLE) && (lat_q == LW'(1));
    win = OWN_NONE;
    if (!rst && ((state_q == IDLE) || ret)) begin
      if (bus.d_req && !(bus.if_req && if_first)) begin
        win = OWN_D;
      end else if (bus.if_req) begin
        win = OWN_I;
      end
    end
  end

  // Memory port and requester outputs; everything idles at zero without a grant.
  always_comb begin
    bus.if_gnt    = (win == OWN_I);
    bus.d_gnt     = (win == OWN_D);
    bus.mem_en    = (win != OWN_NONE);
    bus.mem_we    = (win == OWN_D) && bus.d_we;
    bus.mem_width = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (win == OWN_I) begin
      bus.mem_width = MW_W;
      bus.mem_addr  = {2'b00, bus.if_addr[31:2]};
    end else if (win == OWN_D) begin
      bus.mem_width = bus.d_width;
      bus.mem_addr  = {2'b00, bus.d_addr[31:2]};
      bus.mem_wdata = bus.d_wdata;
    end
    bus.if_rvalid = !rst && ret && (state_q == RD_I);
    bus.d_rvalid  = !rst && ret && (state_q == RD_D);
    bus.if_rdata  = (!rst && ret && (state_q == RD_I)) ? bus.mem_rdata : '0;
    bus.d_rdata   = (!rst && ret && (state_q == RD_D)) ? bus.mem_rdata : '0;
  end

  // Stores leave no outstanding state; only reads occupy the port.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    if (state_q != IDLE) begin
      lat_d = lat_q - LW'(1);
      if (ret) begin
        state_d = IDLE;
      end
    end
    if (win == OWN_I) begin
      state_d = RD_I;
      lat_d   = LW'(MEM_LAT);
    end else if ((win == OWN_D) && !bus.d_we) begin
      state_d = RD_D;
      lat_d   = LW'(MEM_LAT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (bus.if_req && bus.d_req && (win != OWN_NONE)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

  // A requester keeps its request and payload stable until granted.
  if_hold_a: assert property (@(posedge clk) disable iff (rst)
    (bus.if_req && !bus.if_gnt) |=> (bus.if_req && $stable(bus.if_addr)));

  d_hold_a: assert property (@(posedge clk) disable iff (rst)
    (bus.d_req && !bus.d_gnt) |=>
      (bus.d_req && $stable({bus.d_we, bus.d_width, bus.d_addr, bus.d_wdata})));

endmodule
